// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// Optional macro RSTACK_GUARD_EN suppresses CALL-on-full / RET-on-empty and raises a sticky StackErr.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter int               STEP      = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     PCWrite,
    input  logic [2:0]               PCControl,
    input  logic [WIDTH-1:0]         Target,
    input  logic                     Cond,
    output logic [WIDTH-1:0]         PC_out,
    output logic [$clog2(DEPTH):0]   Depth_out,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow,
    output logic                     StackErr
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_JMP  = 3'b001,
        OP_BR   = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_REL  = 3'b101
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [AW:0]      depth_q, depth_d;
    logic [AW-1:0]    sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             push_s;
    logic             full_s, empty_s;
    logic [WIDTH:0]   seq_sum_s;
    logic [WIDTH-1:0] rel_sum_s;
    logic             rel_ovf_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] mem_q [DEPTH];
    op_e              op_s;

    assign op_s      = op_e'(PCControl);
    assign full_s    = (depth_q == DEPTH_W);
    assign empty_s   = (depth_q == {(AW+1){1'b0}});
    assign seq_sum_s = {1'b0, pc_q} + {1'b0, STEP_W};
    assign rel_sum_s = pc_q + Target;
    assign rel_ovf_s = (pc_q[WIDTH-1] == Target[WIDTH-1]) && (rel_sum_s[WIDTH-1] != pc_q[WIDTH-1]);
    // sp_q points at the next free slot, so the newest entry sits one below it.
    assign top_s     = mem_q[sp_q - AW'(1)];

`ifdef RSTACK_GUARD_EN
    logic err_q, err_d;
`endif

    // Next-state selection for PC, stack pointer, depth and wrap flag.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        push_s  = 1'b0;
`ifdef RSTACK_GUARD_EN
        err_d   = err_q;
`endif
        if (PCWrite) begin
            ovf_d = 1'b0;
            case (op_s)
                OP_SEQ: begin
                    pc_d  = seq_sum_s[WIDTH-1:0];
                    ovf_d = seq_sum_s[WIDTH];
                end
                OP_JMP: begin
                    pc_d = Target;
                end
                OP_BR: begin
                    if (Cond) begin
                        pc_d = Target;
                    end else begin
                        pc_d  = seq_sum_s[WIDTH-1:0];
                        ovf_d = seq_sum_s[WIDTH];
                    end
                end
                OP_CALL: begin
`ifdef RSTACK_GUARD_EN
                    if (full_s) begin
                        err_d = 1'b1;
                    end else begin
                        push_s  = 1'b1;
                        pc_d    = Target;
                        ovf_d   = seq_sum_s[WIDTH];
                        sp_d    = sp_q + AW'(1);
                        depth_d = depth_q + (AW+1)'(1);
                    end
`else
                    // On full the write slot is the oldest entry, so it is overwritten in place.
                    push_s = 1'b1;
                    pc_d   = Target;
                    ovf_d  = seq_sum_s[WIDTH];
                    sp_d   = sp_q + AW'(1);
                    if (full_s) begin
                        depth_d = depth_q;
                    end else begin
                        depth_d = depth_q + (AW+1)'(1);
                    end
`endif
                end
                OP_RET: begin
                    if (empty_s) begin
`ifdef RSTACK_GUARD_EN
                        err_d = 1'b1;
`else
                        pc_d  = RESET_VEC;
`endif
                    end else begin
                        pc_d    = top_s;
                        sp_d    = sp_q - AW'(1);
                        depth_d = depth_q - (AW+1)'(1);
                    end
                end
                OP_REL: begin
                    pc_d  = rel_sum_s;
                    ovf_d = rel_ovf_s;
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Architectural state with asynchronous reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= {(AW+1){1'b0}};
            sp_q    <= {AW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stack data storage; contents are meaningless once depth is reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[sp_q] <= seq_sum_s[WIDTH-1:0];
        end
    end

`ifdef RSTACK_GUARD_EN
    // Sticky stack-misuse flag, cleared only by reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign StackErr = err_q;
`else
    assign StackErr = 1'b0;
`endif

    assign PC_out    = pc_q;
    assign Depth_out = depth_q;
    assign Full      = full_s;
    assign Empty     = empty_s;
    assign Overflow  = ovf_q;

endmodule
